te_packet_fifo: RTL and testbench

//  Multi-lane packet buffer between the trace encoder packet emitter and the encapsulator.

---
 rtl/te_pkg.sv | 25 ++
 rtl/te_lane_compactor.sv | 28 ++
 rtl/te_packet_fifo.sv | 129 ++++++++++++
 tb/tb_te_packet_fifo.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/te_pkg.sv
// te_pkg: shared trace-encoder types for the packet FIFO slice.
// Provides the packet type enum, per-entry storage struct and lane limits.
// Optional statistics in te_packet_fifo are enabled by macro TE_PACKET_FIFO_STATS_EN.
package te_pkg;

  localparam int TE_FIFO_MAX_LANES = 8;
  localparam int P_LEN             = 5;
  localparam int PAYLOAD_LEN       = 32;
  // Wide enough to hold a rank or lane count up to TE_FIFO_MAX_LANES.
  localparam int LANE_CNT_W        = $clog2(TE_FIFO_MAX_LANES + 1);

  typedef enum logic [1:0] {
    F_OPC  = 2'h0,
    F_DIFF = 2'h1,
    F_ADDR = 2'h2,
    F_SYNC = 2'h3
  } it_packet_type_e;

  typedef struct packed {
    it_packet_type_e        ptype;
    logic [P_LEN-1:0]       length;
    logic [PAYLOAD_LEN-1:0] payload;
  } te_fifo_entry_t;

endpackage

// File: rtl/te_lane_compactor.sv
// te_lane_compactor: purely combinational prefix ranking of valid lanes.
// Ports: valid (per-lane valid) -> rank (number of valid lanes below each lane),
//        total (number of valid lanes this cycle).
module te_lane_compactor
  import te_pkg::*;
#(
  parameter int N_LANES = 1
) (
  input  logic [N_LANES-1:0]                 valid,
  output logic [N_LANES-1:0][LANE_CNT_W-1:0] rank,
  output logic [LANE_CNT_W-1:0]              total
);

  logic [LANE_CNT_W-1:0] acc;

  // Running sum in ascending lane order: lane i's rank is the count of valid
  // lanes strictly below it, which is its slot offset once gaps are removed.
  always_comb begin
    acc  = '0;
    rank = '0;
    for (int i = 0; i < N_LANES; i++) begin
      rank[i] = acc;
      acc     = acc + LANE_CNT_W'(valid[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/te_packet_fifo.sv
// te_packet_fifo: multi-lane packet buffer, up to N_LANES pushes/cycle, one pop/cycle, FWFT head.
// Ports: clk_i/rst_ni; per-lane packet_*_i + flush_i in; encapsulator_ready_i pops head;
//        packet_*_o head, stall_o (free < N_LANES), fill_level_o; optional macro TE_PACKET_FIFO_STATS_EN adds drop_cnt_o/hwm_o.
module te_packet_fifo
  import te_pkg::*;
#(
  parameter int N_LANES = 1,
  parameter int DEPTH   = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic            [N_LANES-1:0]         packet_valid_i,
  input  it_packet_type_e [N_LANES-1:0]         packet_type_i,
  input  logic [N_LANES-1:0][P_LEN-1:0]         packet_length_i,
  input  logic [N_LANES-1:0][PAYLOAD_LEN-1:0]   packet_payload_i,
  input  logic                                  flush_i,
  input  logic                                  encapsulator_ready_i,
  output logic                                  packet_valid_o,
  output it_packet_type_e                       packet_type_o,
  output logic [P_LEN-1:0]                      packet_length_o,
  output logic [PAYLOAD_LEN-1:0]                packet_payload_o,
  output logic                                  stall_o,
  output logic [$clog2(DEPTH):0]                fill_level_o
`ifdef TE_PACKET_FIFO_STATS_EN
  ,
  output logic [15:0]                           drop_cnt_o,
  output logic [$clog2(DEPTH):0]                hwm_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  te_fifo_entry_t mem [DEPTH];
  te_fifo_entry_t head;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next, free, accepted;
  logic [N_LANES-1:0][LANE_CNT_W-1:0] rank;
  logic [LANE_CNT_W-1:0] total;
  logic [N_LANES-1:0] lane_wr;
  logic pop;

  te_lane_compactor #(.N_LANES(N_LANES)) u_compactor (
    .valid (packet_valid_i),
    .rank  (rank),
    .total (total)
  );

  // Space is judged from the registered count only; a same-cycle pop does not
  // free a slot for this cycle's pushes.
  assign free     = CW'(DEPTH) - count;
  assign accepted = (32'(total) < 32'(free)) ? CW'(total) : free;
  assign pop      = packet_valid_o && encapsulator_ready_i;

  always_comb begin
    lane_wr = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane_wr[i] = packet_valid_i[i] && (32'(rank[i]) < 32'(free));
    end
  end

  assign count_next = count + accepted - CW'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(accepted);  // wraps modulo DEPTH
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
    end
  end

  // Storage is not reset; stale contents are masked by the zeroed head below.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_LANES; i++) begin
      if (lane_wr[i] && !flush_i) begin
        mem[wr_ptr + AW'(rank[i])] <= '{ptype:   packet_type_i[i],
                                        length:  packet_length_i[i],
                                        payload: packet_payload_i[i]};
      end
    end
  end

  assign packet_valid_o = (count != '0);
  assign head           = packet_valid_o ? mem[rd_ptr] : '0;
  assign packet_type_o    = head.ptype;
  assign packet_length_o  = head.length;
  assign packet_payload_o = head.payload;
  assign stall_o          = 32'(free) < N_LANES;
  assign fill_level_o     = count;

`ifdef TE_PACKET_FIFO_STATS_EN
  logic [LANE_CNT_W-1:0] dropped;
  logic [16:0]           drop_sum;
  logic [15:0]           drop_cnt_q;
  logic [CW-1:0]         hwm_q;

  // accepted never exceeds total, so the narrowing cast is lossless.
  assign dropped  = total - LANE_CNT_W'(accepted);
  assign drop_sum = {1'b0, drop_cnt_q} + 17'(dropped);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
      hwm_q      <= '0;
    end else if (!flush_i) begin
      // Lanes discarded by a flush are not protocol drops.
      drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (count_next > hwm_q) begin
        hwm_q <= count_next;
      end
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign hwm_o      = hwm_q;
`endif

endmodule

// File: tb/tb_te_packet_fifo.sv
module tb_te_packet_fifo;
  import te_pkg::*;

  localparam int DEPTH_A = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT A: N_LANES=2, DEPTH=4
  logic [1:0]                   a_valid = '0;
  it_packet_type_e [1:0]        a_type  = '{F_OPC, F_OPC};
  logic [1:0][P_LEN-1:0]        a_len   = '0;
  logic [1:0][PAYLOAD_LEN-1:0]  a_pay   = '0;
  logic                         a_flush = 1'b0;
  logic                         a_rdy   = 1'b0;
  logic                         a_vo, a_stall;
  it_packet_type_e              a_to;
  logic [P_LEN-1:0]             a_lo;
  logic [PAYLOAD_LEN-1:0]       a_po;
  logic [2:0]                   a_fill;
`ifdef TE_PACKET_FIFO_STATS_EN
  logic [15:0] a_drop;
  logic [2:0]  a_hwm;
  int drops_m = 0;
  int hwm_m   = 0;
`endif

  te_packet_fifo #(.N_LANES(2), .DEPTH(DEPTH_A)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .packet_valid_i(a_valid), .packet_type_i(a_type),
    .packet_length_i(a_len), .packet_payload_i(a_pay),
    .flush_i(a_flush), .encapsulator_ready_i(a_rdy),
    .packet_valid_o(a_vo), .packet_type_o(a_to),
    .packet_length_o(a_lo), .packet_payload_o(a_po),
    .stall_o(a_stall), .fill_level_o(a_fill)
`ifdef TE_PACKET_FIFO_STATS_EN
    , .drop_cnt_o(a_drop), .hwm_o(a_hwm)
`endif
  );

  // DUT B: N_LANES=1, DEPTH=8
  logic [0:0]                   b_valid = '0;
  it_packet_type_e [0:0]        b_type  = '{F_OPC};
  logic [0:0][P_LEN-1:0]        b_len   = '0;
  logic [0:0][PAYLOAD_LEN-1:0]  b_pay   = '0;
  logic                         b_rdy   = 1'b0;
  logic                         b_vo, b_stall;
  it_packet_type_e              b_to;
  logic [P_LEN-1:0]             b_lo;
  logic [PAYLOAD_LEN-1:0]       b_po;
  logic [3:0]                   b_fill;
`ifdef TE_PACKET_FIFO_STATS_EN
  logic [15:0] b_drop;
  logic [3:0]  b_hwm;
`endif

  te_packet_fifo #(.N_LANES(1), .DEPTH(8)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .packet_valid_i(b_valid), .packet_type_i(b_type),
    .packet_length_i(b_len), .packet_payload_i(b_pay),
    .flush_i(1'b0), .encapsulator_ready_i(b_rdy),
    .packet_valid_o(b_vo), .packet_type_o(b_to),
    .packet_length_o(b_lo), .packet_payload_o(b_po),
    .stall_o(b_stall), .fill_level_o(b_fill)
`ifdef TE_PACKET_FIFO_STATS_EN
    , .drop_cnt_o(b_drop), .hwm_o(b_hwm)
`endif
  );

  // Scoreboard for DUT A: a plain queue of packets the model says were stored.
  te_fifo_entry_t sbq[$];

  // Drive lanes with distinct content derived from a seed.
  task automatic set_lanes(input logic [1:0] v, input int seed);
    a_valid = v;
    for (int i = 0; i < 2; i++) begin
      a_type[i] = it_packet_type_e'((seed + i) % 4);
      a_len[i]  = P_LEN'(seed + 3 * i + 1);
      a_pay[i]  = 32'hA000_0000 + 32'(seed * 16 + i);
    end
  endtask

  // One clock: at the falling edge, pop-compare the head and push accepted lanes
  // into the scoreboard; return #1 after the rising edge.
  task automatic tick_a();
    te_fifo_entry_t act;
    int free_slots;
    int k;
    @(negedge clk);
    free_slots = DEPTH_A - sbq.size();
    if (a_flush) begin
      sbq.delete();
    end else begin
      if (a_vo && a_rdy) begin
        act = '{ptype: a_to, length: a_lo, payload: a_po};
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got %h, required no pop (empty)", act);
        end else begin
          if (act !== sbq[0]) begin
            n_fail++;
            $display("FAIL pop_data: got %h, required %h", act, sbq[0]);
          end
          void'(sbq.pop_front());
        end
      end
      k = 0;
      for (int i = 0; i < 2; i++) begin
        if (a_valid[i]) begin
          if (k < free_slots) begin
            sbq.push_back('{ptype: a_type[i], length: a_len[i], payload: a_pay[i]});
          end else begin
`ifdef TE_PACKET_FIFO_STATS_EN
            drops_m++;
`endif
          end
          k++;
        end
      end
`ifdef TE_PACKET_FIFO_STATS_EN
      if (sbq.size() > hwm_m) hwm_m = sbq.size();
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (a_vo !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", a_vo); end
    n_tests++;
    if (a_fill !== 3'd0) begin n_fail++; $display("FAIL reset_fill: got %0d, required 0", a_fill); end
    n_tests++;
    if (a_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, required 0", a_stall); end
    n_tests++;
    if ({a_to, a_lo, a_po} !== '0) begin n_fail++; $display("FAIL reset_head: got %h, required 0", {a_to, a_lo, a_po}); end
  endtask

  task automatic test_single();
    a_rdy = 1'b1;
    set_lanes(2'b10, 0);
    a_type[1] = F_SYNC;
    a_len[1]  = 5'd5;
    a_pay[1]  = 32'hCAFE_0001;
    tick_a();
    a_valid = '0;
    n_tests++;
    if (a_vo !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b, required 1", a_vo); end
    n_tests++;
    if (a_to !== F_SYNC) begin n_fail++; $display("FAIL single_type: got %0d, required %0d", a_to, F_SYNC); end
    n_tests++;
    if (a_lo !== 5'd5) begin n_fail++; $display("FAIL single_len: got %0d, required 5", a_lo); end
    tick_a();
    n_tests++;
    if (a_fill !== 3'd0) begin n_fail++; $display("FAIL single_drain: got %0d, required 0", a_fill); end
    a_rdy = 1'b0;
  endtask

  task automatic test_fill_stall();
    a_rdy = 1'b0;
    set_lanes(2'b11, 10); tick_a();
    set_lanes(2'b11, 20); tick_a();
    a_valid = '0;
    n_tests++;
    if (a_fill !== 3'd4) begin n_fail++; $display("FAIL full_fill: got %0d, required 4", a_fill); end
    n_tests++;
    if (a_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b, required 1", a_stall); end
    a_rdy = 1'b1;
    repeat (4) tick_a();
    n_tests++;
    if (a_fill !== 3'd0 || a_vo !== 1'b0) begin
      n_fail++; $display("FAIL full_drain: got fill %0d valid %b, required 0 0", a_fill, a_vo);
    end
    a_rdy = 1'b0;
  endtask

  task automatic test_drop();
    a_rdy = 1'b0;
    set_lanes(2'b11, 30); tick_a();
    set_lanes(2'b01, 40); tick_a();
    n_tests++;
    if (a_fill !== 3'd3) begin n_fail++; $display("FAIL drop_pre_fill: got %0d, required 3", a_fill); end
    set_lanes(2'b11, 50);
    a_rdy = 1'b1;
    tick_a();
    a_valid = '0;
    a_rdy = 1'b0;
    n_tests++;
    if (a_fill !== 3'd3) begin n_fail++; $display("FAIL drop_fill: got %0d, required 3", a_fill); end
`ifdef TE_PACKET_FIFO_STATS_EN
    n_tests++;
    if (a_drop !== 16'(drops_m)) begin n_fail++; $display("FAIL drop_cnt: got %0d, required %0d", a_drop, drops_m); end
    n_tests++;
    if (a_hwm !== 3'(hwm_m)) begin n_fail++; $display("FAIL drop_hwm: got %0d, required %0d", a_hwm, hwm_m); end
`endif
    a_rdy = 1'b1;
    repeat (3) tick_a();
    a_rdy = 1'b0;
  endtask

  task automatic test_hold();
    te_fifo_entry_t act;
    a_rdy = 1'b0;
    set_lanes(2'b11, 60); tick_a();
    set_lanes(2'b11, 70); tick_a();
    a_valid = '0;
    for (int c = 0; c < 5; c++) begin
      tick_a();
      act = '{ptype: a_to, length: a_lo, payload: a_po};
      n_tests++;
      if (a_vo !== 1'b1 || act !== sbq[0]) begin
        n_fail++; $display("FAIL hold_c%0d: got valid %b head %h, required 1 %h", c, a_vo, act, sbq[0]);
      end
    end
    a_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick_a();
      n_tests++;
      if (a_fill !== 3'(3 - c)) begin n_fail++; $display("FAIL hold_drain_c%0d: got %0d, required %0d", c, a_fill, 3 - c); end
    end
    a_rdy = 1'b0;
  endtask

  task automatic test_flush();
    a_rdy = 1'b0;
    set_lanes(2'b11, 80); tick_a();
    n_tests++;
    if (a_fill !== 3'd2) begin n_fail++; $display("FAIL flush_pre_fill: got %0d, required 2", a_fill); end
    set_lanes(2'b11, 90);
    a_flush = 1'b1;
    a_rdy = 1'b1;
    tick_a();
    a_flush = 1'b0;
    a_valid = '0;
    a_rdy = 1'b0;
    n_tests++;
    if (a_fill !== 3'd0 || a_vo !== 1'b0) begin
      n_fail++; $display("FAIL flush: got fill %0d valid %b, required 0 0", a_fill, a_vo);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      set_lanes(2'($urandom_range(0, 3)), int'($urandom_range(0, 1000)));
      a_rdy   = 1'($urandom_range(0, 1));
      a_flush = ($urandom_range(0, 19) == 0);
      tick_a();
      n_tests++;
      if (a_fill !== 3'(sbq.size()) || a_vo !== (sbq.size() != 0) ||
          a_stall !== ((DEPTH_A - sbq.size()) < 2)) begin
        n_fail++;
        $display("FAIL random_c%0d: got fill %0d valid %b stall %b, required fill %0d", c, a_fill, a_vo, a_stall, sbq.size());
      end
    end
    a_valid = '0;
    a_flush = 1'b0;
    a_rdy = 1'b1;
    repeat (5) tick_a();
    a_rdy = 1'b0;
  endtask

  task automatic test_async_reset();
    a_rdy = 1'b0;
    set_lanes(2'b11, 5); tick_a();
    a_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (a_fill !== 3'd0 || a_vo !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got fill %0d valid %b, required 0 0", a_fill, a_vo);
    end
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    te_fifo_entry_t q[$];
    te_fifo_entry_t act;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while ((sent < 20 || got < 20) && cyc < 400) begin
      b_rdy = (cyc % 2 == 0);
      if (sent < 20 && !b_stall) begin
        b_valid   = 1'b1;
        b_type[0] = it_packet_type_e'(sent % 4);
        b_len[0]  = P_LEN'(sent);
        b_pay[0]  = $urandom;
        q.push_back('{ptype: b_type[0], length: b_len[0], payload: b_pay[0]});
        sent++;
      end else begin
        b_valid = 1'b0;
      end
      @(negedge clk);
      if (b_vo && b_rdy) begin
        act = '{ptype: b_to, length: b_lo, payload: b_po};
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected: got %h, required no pop", act);
        end else begin
          if (act !== q[0]) begin
            n_fail++; $display("FAIL b2b_data_%0d: got %h, required %h", got, act, q[0]);
          end
          void'(q.pop_front());
        end
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    b_valid = 1'b0;
    b_rdy = 1'b0;
    n_tests++;
    if (got != 20 || q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: got %0d received %0d left, required 20 received 0 left", got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_drop();
    test_hold();
    test_flush();
    test_random();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
